hdr_emitter: RTL and testbench
==============================

// Module: hdr_emitter
// PURPOSE
//  Downstream neighbour of the action executor. Captures the modified header bytes and egress port
//  when the executor finishes a packet, then serialises them onto a per-beat byte stream with
//  valid/ready backpressure, tagging every beat with the destination port. Feeds the egress queue.
// PARAMETERS
//  BEAT_BYTES   8              bytes per output beat (power of two, 1..16)
//  HDR_LEN      `HDR_MAX_LEN   capture buffer depth in bytes
//  LEN_W        8              width of hdr_len_i
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 asynchronous reset, active-high
//  start_i      in   1                 one-cycle strobe: header/port/len valid this cycle
//  pkt_hdr_i    in   8 x HDR_LEN       header bytes, index 0 = first on wire
//  hdr_len_i    in   LEN_W             valid header bytes
//  out_port_i   in   `NUM_PORTS        one-hot/multi-hot egress port mask
//  busy_o       out  1                 high while a header is held (start_i ignored)
//  done_o       out  1                 one-cycle pulse when a header is fully emitted or dropped
//  err_o        out  1                 sticky: start_i arrived while busy_o; cleared only by rst
//  tx_valid_o   out  1                 beat valid
//  tx_ready_i   in   1                 sink accepts beat
//  tx_data_o    out  8*BEAT_BYTES      beat data, byte k on bits [8k+7:8k]
//  tx_keep_o    out  BEAT_BYTES        byte-valid mask, contiguous from bit 0
//  tx_last_o    out  1                 final beat of the header
//  tx_port_o    out  `NUM_PORTS        port mask, constant for all beats of one header
//  drop_cnt_o   out  16                dropped-header count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; buffer contents unspecified.
//  Reset asserted mid-stream aborts the header: no further beats, no done_o pulse.
//  States: IDLE -> SEND -> IDLE.
//  IDLE:
//   - start_i=1: latch pkt_hdr_i, out_port_i and len = min(hdr_len_i, HDR_LEN); busy_o=1 next cycle.
//   - len==0: no beats; done_o pulses next cycle; stay IDLE.
//   - Otherwise go to SEND; tx_valid_o=1 the next cycle (1-cycle start-to-first-beat latency).
//  SEND:
//   - Beat b carries bytes [b*BEAT_BYTES, b*BEAT_BYTES+BEAT_BYTES-1].
//   - Number of beats = ceil(len/BEAT_BYTES).
//   - Keep bits for bytes >= len are 0; data bytes at those positions are 0.
//   - Beat held stable (data, keep, last, port) while tx_valid_o && !tx_ready_i.
//   - On a handshake, advance the beat counter; the next beat is presented in the following cycle,
//     so back-to-back acceptance gives one beat per cycle.
//   - tx_last_o=1 only on the final beat.
//   - On acceptance of the final beat: tx_valid_o=0, busy_o=0 and done_o=1 next cycle; return to IDLE.
//   - A start_i in that same done cycle is accepted.
//  start_i while busy_o: ignored, captured header undisturbed, err_o set.
//  Byte offset counter width: $clog2(HDR_LEN)+1; never indexes past HDR_LEN-1.
// CONFIGURATION
//  Macro HDR_EMIT_DROP_EN.
//  Defined:
//   - A header captured with out_port_i==0 is dropped: no beats; done_o pulses next cycle.
//   - drop_cnt_o increments, saturating at 16'hFFFF.
//  Undefined:
//   - Such headers are emitted normally with tx_port_o=0.
//   - drop_cnt_o tied to 0.
// STRUCTURE
//  Package emit_pkg:
//   - state enum (EMIT_IDLE, EMIT_SEND);
//   - BEAT_BYTES default;
//   - function num_beats(len) and function keep_mask(len, beat).
//  Sub-module hdr_beat_mux (combinational): buffer + beat index + len -> tx_data_o/tx_keep_o.
//  The FSM and counters stay in hdr_emitter.
// TESTING
//  1. len=20, BEAT_BYTES=8, ready tied 1, port=4'b0010:
//     3 beats on consecutive cycles; keep FF,FF,0F; last on beat 3; port 0010 each beat;
//     done_o 1 cycle after beat 3.
//  2. len=16, tx_ready_i toggled 1-0-0-1:
//     beat 2 data/keep/last stable across stall cycles; exactly 2 beats; keep FF,FF.
//  3. start_i again during SEND with different bytes:
//     stream unchanged; err_o=1 and stays 1 until rst.
//  4. len=0, and separately hdr_len_i=255 (> HDR_LEN):
//     len=0 gives no beats and done_o next cycle; 255 gives ceil(HDR_LEN/8) beats.
//  5. rst pulsed while beat 2 of 3 is stalled:
//     all outputs 0 immediately; no done_o; next start_i emits normally.
//  6. out_port_i=0, with and without HDR_EMIT_DROP_EN:
//     with macro, no beats and drop_cnt_o=1; without, beats emitted with tx_port_o=0.

Source files
------------

// File: rtl/hdr_emitter_pkg.sv
// emit_pkg: shared types and helpers for the header emitter.
//   emit_state_t   FSM state encoding (EMIT_IDLE, EMIT_SEND)
//   BEAT_BYTES_DEF default bytes per output beat
//   num_beats()    beats needed to carry len bytes
//   keep_mask()    byte-valid mask for one beat of a len-byte header
// Also supplies defaults for HDR_MAX_LEN and NUM_PORTS when the build does
// not define them.

`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 32
`endif
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif

package emit_pkg;

    typedef enum logic {EMIT_IDLE, EMIT_SEND} emit_state_t;

    localparam int BEAT_BYTES_DEF = 8;

    function automatic int num_beats(input int len, input int bb);
        return (len + bb - 1) / bb;
    endfunction

    // Bit k set when byte (beat*bb + k) lies inside the header.
    function automatic logic [15:0] keep_mask(input int len, input int beat, input int bb);
        logic [15:0] m;
        m = '0;
        for (int k = 0; k < 16; k++)
            if (k < bb && (beat * bb + k) < len) m[k] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/hdr_emitter_beat_mux.sv
// hdr_beat_mux: combinational beat selector.
//   hdr   captured header, byte i on bits [8i+7:8i]
//   beat  beat index being presented
//   len   valid header bytes (<= HDR_LEN)
//   data  beat bytes, zero past len
//   keep  byte-valid mask, contiguous from bit 0

module hdr_beat_mux
    import emit_pkg::*;
#(
    parameter int BEAT_BYTES = BEAT_BYTES_DEF,
    parameter int HDR_LEN    = `HDR_MAX_LEN,
    parameter int OFF_W      = $clog2(HDR_LEN) + 1
) (
    input  logic [HDR_LEN*8-1:0]    hdr,
    input  logic [OFF_W-1:0]        beat,
    input  logic [OFF_W-1:0]        len,
    output logic [BEAT_BYTES*8-1:0] data,
    output logic [BEAT_BYTES-1:0]   keep
);

    int idx;

    always_comb begin
        idx  = 0;
        data = '0;
        keep = BEAT_BYTES'(keep_mask(int'(len), int'(beat), BEAT_BYTES));
        for (int k = 0; k < BEAT_BYTES; k++) begin
            idx = int'(beat) * BEAT_BYTES + k;
            // keep[k] implies idx < len <= HDR_LEN; the extra bound keeps the
            // select inside the buffer even for a corrupt len.
            if (keep[k] && idx < HDR_LEN)
                data[8*k +: 8] = hdr[8*idx +: 8];
        end
    end

endmodule

// File: rtl/hdr_emitter.sv
// hdr_emitter: captures a modified header and egress port mask on start_i and
// serialises the header onto a valid/ready beat stream tagged with the port.
// Optional feature macro: HDR_EMIT_DROP_EN (drop headers whose port mask is 0
// and count them in drop_cnt_o; otherwise they are emitted with port 0).
// Ports:
//   clk, rst                 clock, async active-high reset
//   start_i                  capture strobe for pkt_hdr_i/hdr_len_i/out_port_i
//   busy_o / done_o / err_o  header held / emit-or-drop finished / sticky overrun
//   tx_valid_o, tx_ready_i   beat handshake
//   tx_data_o, tx_keep_o     beat bytes and byte-valid mask
//   tx_last_o, tx_port_o     final-beat flag, destination port mask
//   drop_cnt_o               saturating dropped-header count

module hdr_emitter
    import emit_pkg::*;
#(
    parameter int BEAT_BYTES = BEAT_BYTES_DEF,
    parameter int HDR_LEN    = `HDR_MAX_LEN,
    parameter int LEN_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [HDR_LEN*8-1:0]    pkt_hdr_i,
    input  logic [LEN_W-1:0]        hdr_len_i,
    input  logic [`NUM_PORTS-1:0]   out_port_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic [BEAT_BYTES*8-1:0] tx_data_o,
    output logic [BEAT_BYTES-1:0]   tx_keep_o,
    output logic                    tx_last_o,
    output logic [`NUM_PORTS-1:0]   tx_port_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int OFF_W = $clog2(HDR_LEN) + 1;

    emit_state_t             state;
    logic [HDR_LEN*8-1:0]    hdr_q;
    logic [OFF_W-1:0]        len_q, nb_q, beat_q;
    logic [`NUM_PORTS-1:0]   port_q;
    logic [OFF_W-1:0]        len_c, nb_c;
    logic                    last_c, drop_c;
    logic [BEAT_BYTES*8-1:0] beat_data;
    logic [BEAT_BYTES-1:0]   beat_keep;

    // Clamp oversized lengths to the buffer depth.
    always_comb begin
        if (int'(hdr_len_i) > HDR_LEN) len_c = OFF_W'(HDR_LEN);
        else                           len_c = OFF_W'(hdr_len_i);
        nb_c = OFF_W'(num_beats(int'(len_c), BEAT_BYTES));
    end

    assign last_c = (beat_q == nb_q - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMIT_IDLE;
            hdr_q      <= '0;
            len_q      <= '0;
            nb_q       <= '0;
            beat_q     <= '0;
            port_q     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            tx_valid_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                EMIT_IDLE: begin
                    if (start_i) begin
                        hdr_q  <= pkt_hdr_i;
                        port_q <= out_port_i;
                        len_q  <= len_c;
                        nb_q   <= nb_c;
                        beat_q <= '0;
                        // Empty or dropped headers finish without a beat.
                        if (len_c == '0 || drop_c) begin
                            done_o <= 1'b1;
                        end else begin
                            state      <= EMIT_SEND;
                            tx_valid_o <= 1'b1;
                            busy_o     <= 1'b1;
                        end
                    end
                end
                EMIT_SEND: begin
                    if (start_i) err_o <= 1'b1;
                    if (tx_ready_i) begin
                        if (last_c) begin
                            state      <= EMIT_IDLE;
                            tx_valid_o <= 1'b0;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state <= EMIT_IDLE;
            endcase
        end
    end

    hdr_beat_mux #(
        .BEAT_BYTES (BEAT_BYTES),
        .HDR_LEN    (HDR_LEN),
        .OFF_W      (OFF_W)
    ) u_mux (
        .hdr  (hdr_q),
        .beat (beat_q),
        .len  (len_q),
        .data (beat_data),
        .keep (beat_keep)
    );

    // Beat fields are forced to 0 whenever no beat is offered, so reset
    // clears them immediately through tx_valid_o.
    assign tx_data_o = tx_valid_o ? beat_data : '0;
    assign tx_keep_o = tx_valid_o ? beat_keep : '0;
    assign tx_last_o = tx_valid_o & last_c;
    assign tx_port_o = tx_valid_o ? port_q : '0;

`ifdef HDR_EMIT_DROP_EN
    logic [15:0] drop_cnt_q;

    assign drop_c     = (out_port_i == '0);
    assign drop_cnt_o = drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt_q <= '0;
        else if (state == EMIT_IDLE && start_i && drop_c && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end
`else
    assign drop_c     = 1'b0;
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hdr_emitter.sv
// Scoreboard bench for hdr_emitter: stimulus pushes expected beats, a monitor
// compares every offered beat against the queue head and pops on handshake.

`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif

module tb_hdr_emitter;

    localparam int BB = 8;
    localparam int HL = 32;
    localparam int NP = `NUM_PORTS;

    typedef struct packed {
        logic [BB*8-1:0] data;
        logic [BB-1:0]   keep;
        logic            last;
        logic [NP-1:0]   port;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic [HL*8-1:0] pkt_hdr_i = '0;
    logic [7:0]      hdr_len_i = '0;
    logic [NP-1:0]   out_port_i = '0;
    logic            busy_o, done_o, err_o, tx_valid_o, tx_last_o;
    logic            tx_ready_i = 1'b1;
    logic [BB*8-1:0] tx_data_o;
    logic [BB-1:0]   tx_keep_o;
    logic [NP-1:0]   tx_port_o;
    logic [15:0]     drop_cnt_o;

    beat_t           exp_q[$];
    logic [BB-1:0]   keep_log[$];
    int errors = 0, checks = 0, done_cnt = 0, beats_seen = 0;

    hdr_emitter #(.BEAT_BYTES(BB), .HDR_LEN(HL), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pkt_hdr_i(pkt_hdr_i),
        .hdr_len_i(hdr_len_i), .out_port_i(out_port_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o), .tx_keep_o(tx_keep_o),
        .tx_last_o(tx_last_o), .tx_port_o(tx_port_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [HL*8-1:0] mk_hdr(input logic [7:0] base);
        logic [HL*8-1:0] h;
        for (int i = 0; i < HL; i++) h[8*i +: 8] = base + 8'(i);
        return h;
    endfunction

    task automatic push_exp(input logic [HL*8-1:0] h, input int len, input logic [NP-1:0] port);
        int eff, nb, idx;
        beat_t e;
        eff = (len > HL) ? HL : len;
        nb  = (eff + BB - 1) / BB;
        for (int b = 0; b < nb; b++) begin
            e = '0;
            e.port = port;
            e.last = (b == nb - 1);
            for (int k = 0; k < BB; k++) begin
                idx = b * BB + k;
                if (idx < eff) begin
                    e.keep[k] = 1'b1;
                    e.data[8*k +: 8] = h[8*idx +: 8];
                end
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare every offered beat against the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) done_cnt++;
            if (tx_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h, no beat expected", tx_data_o);
                end else begin
                    chk("beat_data", tx_data_o, exp_q[0].data);
                    chk("beat_keep", 64'(tx_keep_o), 64'(exp_q[0].keep));
                    chk("beat_last", 64'(tx_last_o), 64'(exp_q[0].last));
                    chk("beat_port", 64'(tx_port_o), 64'(exp_q[0].port));
                    if (tx_ready_i) begin
                        keep_log.push_back(tx_keep_o);
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_hdr(input logic [HL*8-1:0] h, input logic [7:0] len, input logic [NP-1:0] port);
        pkt_hdr_i  = h;
        hdr_len_i  = len;
        out_port_i = port;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (!done_o && n < max) begin
            tick();
            n++;
        end
        chk(name, 64'(done_o), 64'd1);
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_valid"}, 64'(tx_valid_o), 64'd0);
        chk({pfx, "_busy"},  64'(busy_o),     64'd0);
        chk({pfx, "_done"},  64'(done_o),     64'd0);
        chk({pfx, "_err"},   64'(err_o),      64'd0);
        chk({pfx, "_data"},  tx_data_o,       64'd0);
        chk({pfx, "_keep"},  64'(tx_keep_o),  64'd0);
        chk({pfx, "_last"},  64'(tx_last_o),  64'd0);
        chk({pfx, "_port"},  64'(tx_port_o),  64'd0);
        chk({pfx, "_drop"},  64'(drop_cnt_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0;
        logic [HL*8-1:0] h;

        repeat (2) tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // 1: len 20 -> keep FF,FF,0F on consecutive cycles, done one cycle later
        h = mk_hdr(8'h10);
        push_exp(h, 20, 4'b0010);
        keep_log.delete();
        b0 = beats_seen;
        start_hdr(h, 8'd20, 4'b0010);
        chk("t1_first_valid", 64'(tx_valid_o), 64'd1);
        chk("t1_busy", 64'(busy_o), 64'd1);
        tick(); tick(); tick();
        chk("t1_done", 64'(done_o), 64'd1);
        chk("t1_valid_off", 64'(tx_valid_o), 64'd0);
        chk("t1_busy_off", 64'(busy_o), 64'd0);
        tick();
        chk("t1_done_pulse", 64'(done_o), 64'd0);
        chk("t1_beats", 64'(beats_seen - b0), 64'd3);
        if (keep_log.size() == 3) begin
            chk("t1_keep0", 64'(keep_log[0]), 64'hFF);
            chk("t1_keep1", 64'(keep_log[1]), 64'hFF);
            chk("t1_keep2", 64'(keep_log[2]), 64'h0F);
        end else begin
            chk("t1_keep_count", 64'(keep_log.size()), 64'd3);
        end

        // 2: len 16 with ready 1-0-0-1, beat 2 held through the stall
        h = mk_hdr(8'h40);
        push_exp(h, 16, 4'b0101);
        keep_log.delete();
        b0 = beats_seen;
        start_hdr(h, 8'd16, 4'b0101);
        tick();
        tx_ready_i = 1'b0;
        tick(); tick();
        chk("t2_stall_valid", 64'(tx_valid_o), 64'd1);
        tx_ready_i = 1'b1;
        tick();
        chk("t2_done", 64'(done_o), 64'd1);
        tick();
        chk("t2_beats", 64'(beats_seen - b0), 64'd2);
        if (keep_log.size() == 2) begin
            chk("t2_keep0", 64'(keep_log[0]), 64'hFF);
            chk("t2_keep1", 64'(keep_log[1]), 64'hFF);
        end else begin
            chk("t2_keep_count", 64'(keep_log.size()), 64'd2);
        end

        // 3: start during SEND is ignored and flags err
        h = mk_hdr(8'h80);
        push_exp(h, 24, 4'b1000);
        b0 = beats_seen;
        start_hdr(h, 8'd24, 4'b1000);
        tick();
        start_hdr(mk_hdr(8'hC0), 8'd8, 4'b0001);
        wait_done("t3_done", 10);
        tick();
        chk("t3_beats", 64'(beats_seen - b0), 64'd3);
        chk("t3_err", 64'(err_o), 64'd1);

        // 4a: len 0 -> no beats, done next cycle
        b0 = beats_seen;
        start_hdr(mk_hdr(8'h05), 8'd0, 4'b0010);
        chk("t4_len0_done", 64'(done_o), 64'd1);
        chk("t4_len0_valid", 64'(tx_valid_o), 64'd0);
        chk("t4_len0_busy", 64'(busy_o), 64'd0);
        tick();
        chk("t4_len0_beats", 64'(beats_seen - b0), 64'd0);

        // 4b: len 255 clamps to the 32-byte buffer -> 4 beats
        h = mk_hdr(8'hA0);
        push_exp(h, 255, 4'b0011);
        b0 = beats_seen;
        start_hdr(h, 8'd255, 4'b0011);
        wait_done("t4_big_done", 20);
        tick();
        chk("t4_big_beats", 64'(beats_seen - b0), 64'd4);
        chk("t4_err_sticky", 64'(err_o), 64'd1);

        // 5: reset while beat 2 of 3 is stalled
        h = mk_hdr(8'h20);
        push_exp(h, 20, 4'b0100);
        start_hdr(h, 8'd20, 4'b0100);
        tick();
        tx_ready_i = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk_idle_outputs("t5_rst");
        exp_q.delete();
        d0 = done_cnt;
        tick(); tick();
        rst = 1'b0;
        tx_ready_i = 1'b1;
        tick(); tick();
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        h = mk_hdr(8'h60);
        push_exp(h, 12, 4'b0100);
        b0 = beats_seen;
        start_hdr(h, 8'd12, 4'b0100);
        wait_done("t5_restart_done", 10);
        tick();
        chk("t5_restart_beats", 64'(beats_seen - b0), 64'd2);

        // 6: zero port mask
        h = mk_hdr(8'h33);
        b0 = beats_seen;
`ifdef HDR_EMIT_DROP_EN
        start_hdr(h, 8'd9, '0);
        chk("t6_drop_done", 64'(done_o), 64'd1);
        chk("t6_drop_valid", 64'(tx_valid_o), 64'd0);
        tick();
        chk("t6_drop_cnt", 64'(drop_cnt_o), 64'd1);
        chk("t6_drop_beats", 64'(beats_seen - b0), 64'd0);
`else
        push_exp(h, 9, '0);
        start_hdr(h, 8'd9, '0);
        wait_done("t6_done", 10);
        tick();
        chk("t6_beats", 64'(beats_seen - b0), 64'd2);
        chk("t6_drop_cnt", 64'(drop_cnt_o), 64'd0);
`endif

        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
